// File: rtl/lab3_divider_datapath_if.sv
// Purpose: bundles the switch/button inputs and display outputs of the lab3 divider datapath.
// Ports  : master = push-button controller / board side (drives operands and controls, reads result),
//          slave  = divider datapath (reads operands and controls, drives RESULT/BUSY/DONE/DIV_BY_ZERO).
// Signal names follow the board-level names used by the upstream controller.
interface lab3_divider_datapath_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] SWITCHES;
  logic             dividendLOAD;
  logic             divisorLOAD;
  logic             trigger;
  logic             remainderDISPLAY;
  logic [WIDTH-1:0] RESULT;
  logic             BUSY;
  logic             DONE;
  logic             DIV_BY_ZERO;

  modport master (
    output SWITCHES, dividendLOAD, divisorLOAD, trigger, remainderDISPLAY,
    input  RESULT, BUSY, DONE, DIV_BY_ZERO
  );

  modport slave (
    input  SWITCHES, dividendLOAD, divisorLOAD, trigger, remainderDISPLAY,
    output RESULT, BUSY, DONE, DIV_BY_ZERO
  );
endinterface

// File: rtl/lab3_divider_datapath.sv
// Purpose: sequential restoring divider, one quotient bit per cycle, started on a trigger rising edge.
// Latency: WIDTH RUN cycles from start to DONE (+1 FIXUP cycle with LAB3_SIGNED_EN); RESULT lags one cycle.
// Backpressure: none; loads are ignored and trigger edges are dropped while RUN is active.
// Ports: CLK, RESET (sync, active-high), dp_if (slave modport: SWITCHES, dividendLOAD, divisorLOAD,
//        trigger, remainderDISPLAY in; RESULT, BUSY, DONE, DIV_BY_ZERO out).
// Optional: define LAB3_SIGNED_EN for two's-complement operands (adds a FIXUP state).
module lab3_divider_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  lab3_divider_datapath_if.slave dp_if
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef LAB3_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2, FIXUP = 2'd3} state_t;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  // Magnitude of a two's-complement value; the most-negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg(v) : v;
  endfunction
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic             trig_q, trig_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor as used by the core (magnitude in signed mode)
  logic [WIDTH-1:0] a_q, a_d;           // partial remainder; always < divisor between iterations
  logic [WIDTH-1:0] qsh_q, qsh_d;       // dividend shifting out / quotient shifting in
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;
`ifdef LAB3_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic             start;
  logic             load_any;
  logic [WIDTH:0]   shifted;            // {A,Q} << 1, upper WIDTH+1 bits
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] q_step;

  always_comb begin
    state_d    = state_q;
    trig_d     = dp_if.trigger;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    dvs_d      = dvs_q;
    a_d        = a_q;
    qsh_d      = qsh_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    result_d   = dp_if.remainderDISPLAY ? rem_q : quot_q;
`ifdef LAB3_SIGNED_EN
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
`endif

    start    = dp_if.trigger & ~trig_q;
    load_any = dp_if.dividendLOAD | dp_if.divisorLOAD;

    // One restoring step. With A < divisor the shifted value is below 2*divisor,
    // so the MSB of the WIDTH+1-bit trial difference is exactly its sign.
    shifted = {a_q, qsh_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    fits    = ~trial[WIDTH];
    a_step  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_step  = {qsh_q[WIDTH-2:0], fits};

    case (state_q)
      IDLE, FIN: begin
        if (dp_if.dividendLOAD) dividend_d = dp_if.SWITCHES;
        if (dp_if.divisorLOAD)  divisor_d  = dp_if.SWITCHES;
        if (load_any) begin
          // A load always wins over a simultaneous start and invalidates the result.
          state_d = IDLE;
          dbz_d   = 1'b0;
        end else if (start) begin
          dbz_d = 1'b0;
          if (divisor_q == '0) begin
            state_d = FIN;
            quot_d  = '1;
            rem_d   = dividend_q;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            a_d     = '0;
            cnt_d   = '0;
`ifdef LAB3_SIGNED_EN
            qsh_d     = mag(dividend_q);
            dvs_d     = mag(divisor_q);
            neg_quo_d = dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1];
            neg_rem_d = dividend_q[WIDTH-1];
`else
            qsh_d     = dividend_q;
            dvs_d     = divisor_q;
`endif
          end
        end
      end

      RUN: begin
        a_d   = a_step;
        qsh_d = q_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
`ifdef LAB3_SIGNED_EN
          state_d = FIXUP;
`else
          state_d = FIN;
          quot_d  = q_step;
          rem_d   = a_step;
`endif
        end
      end

`ifdef LAB3_SIGNED_EN
      FIXUP: begin
        // Truncation toward zero: quotient sign from operand signs, remainder
        // follows the dividend. -max/-1 wraps back to the most-negative value.
        quot_d  = neg_quo_q ? neg(qsh_q) : qsh_q;
        rem_d   = neg_rem_q ? neg(a_q) : a_q;
        state_d = FIN;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      trig_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      dvs_q      <= '0;
      a_q        <= '0;
      qsh_q      <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
`ifdef LAB3_SIGNED_EN
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      dvs_q      <= dvs_d;
      a_q        <= a_d;
      qsh_q      <= qsh_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
`ifdef LAB3_SIGNED_EN
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign dp_if.RESULT      = result_q;
  assign dp_if.BUSY        = (state_q == RUN);
  assign dp_if.DONE        = (state_q == FIN);
  assign dp_if.DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_lab3_divider_datapath.sv
// Purpose: directed bench for lab3_divider_datapath (WIDTH=8) with hand-computed expected values.
// Timing: inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Covers reset, several divisions, divide-by-zero, held trigger, RUN-time interference, mid-RUN reset.
module tb_lab3_divider_datapath;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  lab3_divider_datapath_if #(.WIDTH(W)) dp ();

  lab3_divider_datapath #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .dp_if (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    dp.SWITCHES     = dvd;
    dp.dividendLOAD = 1'b1;
    tick();
    dp.dividendLOAD = 1'b0;
    dp.SWITCHES     = dvs;
    dp.divisorLOAD  = 1'b1;
    tick();
    dp.divisorLOAD  = 1'b0;
    tick();
  endtask

  // Start a division, measure the BUSY window, then check both results.
  task automatic run_case(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
    int n;
    do_load(dvd, dvs);
    chk({tag, "_dbz_after_load"}, 32'(dp.DIV_BY_ZERO), 0);
    dp.trigger = 1'b1;
    tick();
    dp.trigger = 1'b0;
    chk({tag, "_busy_at_start"}, 32'(dp.BUSY), 1);
    chk({tag, "_done_clear_at_start"}, 32'(dp.DONE), 0);
    n = 0;
    while (dp.BUSY === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(W));
`ifdef LAB3_SIGNED_EN
    chk({tag, "_done_in_fixup"}, 32'(dp.DONE), 0);
    tick();
`endif
    chk({tag, "_done"}, 32'(dp.DONE), 1);
    chk({tag, "_dbz"}, 32'(dp.DIV_BY_ZERO), 0);
    dp.remainderDISPLAY = 1'b0;
    tick();
    chk({tag, "_quot"}, 32'(dp.RESULT), 32'(eq));
    dp.remainderDISPLAY = 1'b1;
    #1;
    chk({tag, "_rem_lag"}, 32'(dp.RESULT), 32'(eq));
    tick();
    chk({tag, "_rem"}, 32'(dp.RESULT), 32'(er));
    dp.remainderDISPLAY = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int rises;
    logic prev;
    total = 0;
    bad   = 0;
    rst                 = 1'b1;
    dp.SWITCHES         = '0;
    dp.dividendLOAD     = 1'b0;
    dp.divisorLOAD      = 1'b0;
    dp.trigger          = 1'b0;
    dp.remainderDISPLAY = 1'b0;
    tick();
    tick();
    chk("rst_result", 32'(dp.RESULT), 0);
    chk("rst_busy", 32'(dp.BUSY), 0);
    chk("rst_done", 32'(dp.DONE), 0);
    chk("rst_dbz", 32'(dp.DIV_BY_ZERO), 0);
    rst = 1'b0;
    tick();

    run_case("d100_7", 8'd100, 8'd7, 8'd14, 8'd2);
    run_case("d255_1", 8'd255, 8'd1, 8'd255, 8'd0);
    run_case("d3_10", 8'd3, 8'd10, 8'd0, 8'd3);

    // Divide by zero: straight to FIN one cycle after the start edge.
    do_load(8'd5, 8'd0);
    dp.trigger = 1'b1;
    tick();
    dp.trigger = 1'b0;
    chk("dz_busy", 32'(dp.BUSY), 0);
    chk("dz_done", 32'(dp.DONE), 1);
    chk("dz_flag", 32'(dp.DIV_BY_ZERO), 1);
    tick();
    chk("dz_quot", 32'(dp.RESULT), 32'h0ff);
    dp.remainderDISPLAY = 1'b1;
    tick();
    chk("dz_rem", 32'(dp.RESULT), 5);
    dp.remainderDISPLAY = 1'b0;
    tick();

    // Trigger held high for 30 cycles: exactly one BUSY window.
    do_load(8'd100, 8'd7);
    dp.trigger = 1'b1;
    n     = 0;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (dp.BUSY === 1'b1) n++;
      if (dp.BUSY === 1'b1 && prev == 1'b0) rises++;
      prev = dp.BUSY;
    end
    dp.trigger = 1'b0;
    chk("hold_busy_cycles", 32'(n), 32'(W));
    chk("hold_busy_windows", 32'(rises), 1);
    tick();
    chk("hold_quot", 32'(dp.RESULT), 14);

    // Trigger edge and dividend load during RUN must both be ignored.
    dp.trigger = 1'b1;
    tick();
    dp.trigger = 1'b0;
    tick();
    tick();
    dp.trigger      = 1'b1;
    dp.SWITCHES     = 8'h55;
    dp.dividendLOAD = 1'b1;
    tick();
    dp.dividendLOAD = 1'b0;
    dp.trigger      = 1'b0;
    n = 0;
    while (dp.BUSY === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("run_ign_busy_left", 32'(n), 32'(W - 3));
    for (int i = 0; i < 4; i++) tick();
    chk("run_ign_no_requeue", 32'(dp.BUSY), 0);
    chk("run_ign_quot", 32'(dp.RESULT), 14);
    dp.remainderDISPLAY = 1'b1;
    tick();
    chk("run_ign_rem", 32'(dp.RESULT), 2);
    dp.remainderDISPLAY = 1'b0;
    // Re-run with the registers as they stand: dividend must still be 100.
    dp.trigger = 1'b1;
    tick();
    dp.trigger = 1'b0;
    for (int i = 0; i < W + 3; i++) tick();
    chk("run_ign_rerun_quot", 32'(dp.RESULT), 14);

    // Reset in the middle of RUN discards everything.
    dp.trigger = 1'b1;
    tick();
    dp.trigger = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst_busy_before", 32'(dp.BUSY), 1);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(dp.BUSY), 0);
    chk("midrst_done", 32'(dp.DONE), 0);
    chk("midrst_result", 32'(dp.RESULT), 0);
    chk("midrst_dbz", 32'(dp.DIV_BY_ZERO), 0);
    rst = 1'b0;
    tick();
    run_case("post_rst_100_7", 8'd100, 8'd7, 8'd14, 8'd2);

`ifdef LAB3_SIGNED_EN
    run_case("s_m7_2", 8'hF9, 8'h02, 8'hFD, 8'hFF);
    run_case("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lab3_divider_datapath.md
Name: lab3_divider_datapath

Overview:
- Sequential restoring divider; sits directly downstream of the lab3 push-button controller and consumes its dividendLOAD, divisorLOAD, trigger and remainderDISPLAY levels.
- Captures dividend and divisor from board switches, runs a one-bit-per-cycle division on a trigger rising edge, and drives quotient or remainder to the display/LED stage.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RESET  input  1  synchronous, active-high reset.
- SWITCHES  input  WIDTH  operand value from board switches.
- dividendLOAD  input  1  level; capture SWITCHES into dividend register.
- divisorLOAD  input  1  level; capture SWITCHES into divisor register.
- trigger  input  1  level; rising edge starts a division.
- remainderDISPLAY  input  1  level; 1 selects remainder on RESULT, 0 selects quotient.
- RESULT  output  WIDTH  registered display value.
- BUSY  output  1  high while the division iterates.
- DONE  output  1  high when quotient/remainder registers hold a valid result.
- DIV_BY_ZERO  output  1  high with DONE when the divisor was 0 at start.

Behaviour:
- Reset (RESET=1 at a clock edge): dividend, divisor, quotient, remainder, RESULT = 0; BUSY = DONE = DIV_BY_ZERO = 0; FSM = IDLE; trigger edge register = 0. Reset is honoured in every state, including mid-RUN; the partial result is discarded.
- FSM states: IDLE, RUN, FIN.
- Loads, IDLE or FIN only:
  - dividendLOAD=1 copies SWITCHES to dividend every cycle it is held.
  - divisorLOAD=1 does the same for divisor.
  - Both high: both registers load.
  - Any load in FIN clears DONE and DIV_BY_ZERO and returns to IDLE.
  - Loads during RUN are ignored.
- Start:
  - trig_q registers trigger every cycle; start = trigger & ~trig_q, accepted in IDLE or FIN only.
  - A start with a simultaneous load: the load wins, no start.
  - A held trigger starts exactly one division.
  - A rising edge during RUN is dropped, not queued.
- RUN:
  - Restoring algorithm with a WIDTH+1-bit partial remainder A, shift register Q = dividend, iteration counter.
  - Each cycle: shift {A,Q} left by 1; trial = A - {0,divisor}; if trial is non-negative, A = trial and Q[0] = 1, else Q[0] = 0.
  - Exactly WIDTH RUN cycles, then FIN.
  - quotient = Q, remainder = A[WIDTH-1:0].
- Latency, with start sampled at edge k:
  - BUSY = 1 from edge k to edge k+WIDTH.
  - DONE = 1 after edge k+WIDTH and stays high until a load, a new start, or reset.
  - A new start from FIN clears DONE the same edge BUSY rises.
- Divide by zero:
  - divisor == 0 at start: no RUN; next state is FIN after one cycle.
  - quotient = all ones, remainder = dividend, DIV_BY_ZERO = 1, BUSY stays 0.
- RESULT is registered every cycle as remainderDISPLAY ? remainder : quotient.
  - It reflects a remainderDISPLAY change one cycle later.
  - During RUN it holds the previous result registers, which update only on entry to FIN.
- All arithmetic is unsigned, and no result overflows in unsigned mode.

Optional Feature:
- Macro LAB3_SIGNED_EN.
- Defined: operands are two's complement.
  - Divide magnitudes with the same core, then fix signs.
  - Quotient is negated if the operand signs differ (truncation toward zero); remainder takes the dividend's sign.
  - Adds one FIXUP cycle between RUN and FIN, so DONE appears one cycle later.
  - Most-negative / -1 gives quotient = most-negative, remainder = 0.
  - Divide-by-zero gives quotient = -1 (all ones), remainder = dividend.
- Undefined: unsigned only, no FIXUP state.

Test Plan:
- Load 100, load 7, trigger edge, WIDTH=8 -> BUSY for 8 cycles; DONE at start+8; RESULT=14 with remainderDISPLAY=0, 2 with remainderDISPLAY=1 (one cycle later).
- 255/1 -> quotient 255, remainder 0; 3/10 -> quotient 0, remainder 3.
- Divisor 0, dividend 5, trigger -> BUSY never asserts; DONE and DIV_BY_ZERO high one cycle after start; quotient 0xFF, remainder 5.
- Trigger held high 30 cycles -> exactly one 8-cycle BUSY window. Edge during RUN and pulse of dividendLOAD with SWITCHES=0x55 during RUN -> both ignored, result unchanged.
- RESET asserted at RUN cycle 4 -> next edge: all outputs 0, IDLE; a fresh 100/7 then completes correctly.
- With LAB3_SIGNED_EN: -7/2 (0xF9/0x02) -> quotient 0xFD, remainder 0xFF; -128/-1 -> quotient 0x80, remainder 0; DONE at start+9.
